// File: rtl/tap_word_packer_pkg.sv
// Shared definitions for the tap word packer: default sizes and buffer occupancy encodings.
package tap_word_packer_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/tap_word_packer_skid_fifo2.sv
// Two-entry FIFO holding completed word pairs; head entry is presented directly from a register.
module tap_word_packer_skid_fifo2
  import tap_word_packer_pkg::*;
#(
  parameter int unsigned DW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          drop_c
);

  occ_e          occ;
  logic [DW-1:0] tail;
  logic          full;

  // A push into a full buffer with no pop on the same edge is discarded.
  assign drop_c = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ   <= OCC_EMPTY;
      dout  <= '0;
      tail  <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (push) begin
            dout  <= din;
            occ   <= OCC_ONE;
            empty <= 1'b0;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            dout <= din;
          end else if (push) begin
            tail <= din;
            occ  <= OCC_TWO;
            full <= 1'b1;
          end else if (pop) begin
            occ   <= OCC_EMPTY;
            empty <= 1'b1;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            dout <= tail;
            if (push) begin
              tail <= din;
            end else begin
              occ  <= OCC_ONE;
              full <= 1'b0;
            end
          end
        end
        default: begin
          occ   <= OCC_EMPTY;
          empty <= 1'b1;
          full  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tap_word_packer.sv
// Packs two serial tap streams LSB-first into words, flags per-word disagreement,
// buffers word pairs for a valid/ready consumer and counts mismatched bits.
module tap_word_packer
  import tap_word_packer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             en,
  input  logic             I0,
  input  logic             I1,
  output logic [WIDTH-1:0] O_data0,
  output logic [WIDTH-1:0] O_data1,
  output logic             O_mismatch,
  output logic             O_valid,
  input  logic             O_ready,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             overflow
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DW = 2 * WIDTH + 1;

  logic [BW-1:0]    bitcnt;
  logic [WIDTH-1:0] sr0, sr1, sr0_nxt, sr1_nxt;
  logic             flag, flag_nxt;
  logic             word_done_c;
  logic [DW-1:0]    head;
  logic             fifo_empty;
  logic             drop_c;

  // Word contents including the bit being sampled this cycle.
  always_comb begin
    sr0_nxt         = sr0;
    sr1_nxt         = sr1;
    sr0_nxt[bitcnt] = I0;
    sr1_nxt[bitcnt] = I1;
    flag_nxt        = flag | (I0 ^ I1);
    word_done_c     = en && (bitcnt == BW'(WIDTH - 1));
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      bitcnt         <= '0;
      sr0            <= '0;
      sr1            <= '0;
      flag           <= 1'b0;
      mismatch_count <= '0;
      overflow       <= 1'b0;
    end else begin
      if (en) begin
        sr0    <= sr0_nxt;
        sr1    <= sr1_nxt;
        flag   <= word_done_c ? 1'b0 : flag_nxt;
        bitcnt <= word_done_c ? '0 : bitcnt + BW'(1);
      end
      if (en && (I0 != I1) && (mismatch_count != '1)) begin
        mismatch_count <= mismatch_count + CNT_W'(1);
      end
      if (drop_c) begin
        overflow <= 1'b1;
      end
    end
  end

  tap_word_packer_skid_fifo2 #(
    .DW (DW)
  ) u_fifo (
    .clk    (CLK),
    .rst    (ASYNCRESET),
    .push   (word_done_c),
    .din    ({flag_nxt, sr1_nxt, sr0_nxt}),
    .pop    (O_ready),
    .dout   (head),
    .empty  (fifo_empty),
    .drop_c (drop_c)
  );

  assign O_data0    = head[WIDTH-1:0];
  assign O_data1    = head[2*WIDTH-1:WIDTH];
  assign O_mismatch = head[DW-1];
  assign O_valid    = ~fifo_empty;

endmodule

// File: tb/tb_tap_word_packer.sv
// Directed bench for tap_word_packer with a queue-based reference model checked every cycle.
module tb_tap_word_packer;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic i0 = 1'b0;
  logic i1 = 1'b0;
  logic rdy = 1'b0;

  logic [W-1:0]  d0, d1, d0_b, d1_b;
  logic          mm, mm_b, vld, vld_b, ovf_o, ovf_b;
  logic [15:0]   cnt_o;
  logic [1:0]    cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tap_word_packer #(.WIDTH(W), .CNT_W(16)) dut (
    .CLK(clk), .ASYNCRESET(rst), .en(en), .I0(i0), .I1(i1),
    .O_data0(d0), .O_data1(d1), .O_mismatch(mm), .O_valid(vld), .O_ready(rdy),
    .mismatch_count(cnt_o), .overflow(ovf_o)
  );

  tap_word_packer #(.WIDTH(W), .CNT_W(2)) dut_small (
    .CLK(clk), .ASYNCRESET(rst), .en(en), .I0(i0), .I1(i1),
    .O_data0(d0_b), .O_data1(d1_b), .O_mismatch(mm_b), .O_valid(vld_b), .O_ready(rdy),
    .mismatch_count(cnt_b), .overflow(ovf_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: word pairs as a queue, bit assembly by shift-and-or.
  typedef struct {
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    logic         m;
  } pair_t;

  pair_t        q[$];
  int           m_idx;
  logic [W-1:0] m_a0, m_a1;
  logic         m_am;
  int           m_cnt, m_cnt2;
  bit           m_ovf;
  int           m_pre;
  bit           m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_idx = 0; m_a0 = '0; m_a1 = '0; m_am = 1'b0;
      m_cnt = 0; m_cnt2 = 0; m_ovf = 1'b0;
    end else begin
      m_pre = q.size();
      m_pop = rdy && (m_pre > 0);
      if (m_pop) void'(q.pop_front());
      if (en) begin
        m_a0 = m_a0 | (W'(i0) << m_idx);
        m_a1 = m_a1 | (W'(i1) << m_idx);
        m_am = m_am | (i0 ^ i1);
        if (i0 != i1) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
        m_idx++;
        if (m_idx == W) begin
          if (m_pre == 2 && !m_pop) m_ovf = 1'b1;
          else q.push_back('{m_a0, m_a1, m_am});
          m_idx = 0; m_a0 = '0; m_a1 = '0; m_am = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", 32'(vld), 32'(q.size() > 0));
      chk("valid_small", 32'(vld_b), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("data0", 32'(d0), 32'(q[0].w0));
        chk("data1", 32'(d1), 32'(q[0].w1));
        chk("mismatch", 32'(mm), 32'(q[0].m));
        chk("data0_small", 32'(d0_b), 32'(q[0].w0));
        chk("mismatch_small", 32'(mm_b), 32'(q[0].m));
      end
      chk("count", 32'(cnt_o), 32'(m_cnt));
      chk("count_small", 32'(cnt_b), 32'(m_cnt2));
      chk("overflow", 32'(ovf_o), 32'(m_ovf));
      chk("overflow_small", 32'(ovf_b), 32'(m_ovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit gap, input bit rdy_last);
    for (int k = 0; k < int'(W); k++) begin
      en = 1'b1;
      i0 = a[k];
      i1 = b[k];
      if (rdy_last && k == int'(W) - 1) rdy = 1'b1;
      step();
      if (gap && k != int'(W) - 1) begin
        en = 1'b0;
        i0 = 1'($urandom);
        i1 = 1'($urandom);
        step();
      end
    end
    en = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_data0", 32'(d0), 32'd0);
    chk("rst_count", 32'(cnt_o), 32'd0);
    chk("rst_overflow", 32'(ovf_o), 32'd0);
    rst = 1'b0;
    rdy = 1'b1;

    // Matching streams
    send(8'hA5, 8'hA5, 1'b0, 1'b0);
    chk("t1_valid", 32'(vld), 32'd1);
    chk("t1_data0", 32'(d0), 32'hA5);
    chk("t1_data1", 32'(d1), 32'hA5);
    chk("t1_mismatch", 32'(mm), 32'd0);
    idle(1);
    chk("t1_pulse_end", 32'(vld), 32'd0);

    // One differing bit
    send(8'h3C, 8'h3D, 1'b0, 1'b0);
    chk("t2_data0", 32'(d0), 32'h3C);
    chk("t2_data1", 32'(d1), 32'h3D);
    chk("t2_mismatch", 32'(mm), 32'd1);
    chk("t2_count", 32'(cnt_o), 32'd1);
    idle(1);

    // Gapped enable
    send(8'h5A, 8'h5A, 1'b1, 1'b0);
    chk("t5_valid", 32'(vld), 32'd1);
    chk("t5_data0", 32'(d0), 32'h5A);
    chk("t5_data1", 32'(d1), 32'h5A);
    idle(1);

    // Overflow with consumer stalled
    rdy = 1'b0;
    send(8'h01, 8'h01, 1'b0, 1'b0);
    send(8'h02, 8'h02, 1'b0, 1'b0);
    send(8'h03, 8'h03, 1'b0, 1'b0);
    chk("t3_overflow", 32'(ovf_o), 32'd1);
    chk("t3_head0", 32'(d0), 32'h01);
    idle(2);
    chk("t3_stall_hold", 32'(d0), 32'h01);
    rdy = 1'b1;
    idle(1);
    chk("t3_head1", 32'(d0), 32'h02);
    idle(1);
    chk("t3_drained", 32'(vld), 32'd0);

    rst = 1'b1;
    #1;
    chk("rst2_overflow", 32'(ovf_o), 32'd0);
    #1;
    rst = 1'b0;

    // Pop on the same edge the third word lands
    rdy = 1'b0;
    send(8'h01, 8'h01, 1'b0, 1'b0);
    send(8'h02, 8'h02, 1'b0, 1'b0);
    send(8'h03, 8'h03, 1'b0, 1'b1);
    chk("t4_overflow", 32'(ovf_o), 32'd0);
    chk("t4_head1", 32'(d0), 32'h02);
    idle(1);
    chk("t4_head2", 32'(d0), 32'h03);
    idle(1);
    chk("t4_drained", 32'(vld), 32'd0);

    // Saturation and asynchronous reset mid-word with a buffered entry
    rdy = 1'b0;
    send(8'h77, 8'h77, 1'b0, 1'b0);
    chk("t6_buffered", 32'(vld), 32'd1);
    for (int k = 0; k < 5; k++) begin
      en = 1'b1; i0 = 1'b1; i1 = 1'b0;
      step();
    end
    en = 1'b0;
    chk("t6_count_sat", 32'(cnt_b), 32'd3);
    chk("t6_count_wide", 32'(cnt_o), 32'd5);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(vld), 32'd0);
    chk("t6_rst_count", 32'(cnt_o), 32'd0);
    chk("t6_rst_count_small", 32'(cnt_b), 32'd0);
    chk("t6_rst_data0", 32'(d0), 32'd0);
    chk("t6_rst_mismatch", 32'(mm), 32'd0);
    chk("t6_rst_overflow", 32'(ovf_o), 32'd0);
    #1;
    rst = 1'b0;
    rdy = 1'b1;
    send(8'hC3, 8'hC3, 1'b0, 1'b0);
    chk("t6_fresh_data0", 32'(d0), 32'hC3);
    chk("t6_fresh_mismatch", 32'(mm), 32'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
